// File: rtl/seq_sub_if.sv
// Handshake and operand/result bundle for the multi-cycle subtractor.
// The master side issues operations and the slave side computes them.
interface seq_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dif;
  logic             bor;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, dif, bor, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, dif, bor, ovf
  );
endinterface

// File: rtl/seq_sub.sv
// Multi-cycle subtractor: a - b - bin, DIGIT bits per clock, with the borrow
// carried between digits in a flip-flop. The results are registered and held until the next completion.
module seq_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  seq_sub_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("seq_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic             brw_r, brw_s;
  logic [WIDTH-1:0] res_r, res_s;
  logic [WIDTH-1:0] dif_r, dif_s;
  logic             bor_r, bor_s;
  logic             ovf_r, ovf_s;
  logic             done_r, done_s;
  logic             busy_r, busy_s;
  logic [DIGIT+1:0] step_s;
  int               idx_s;

  // Ripple of full-subtractor cells over one digit.
  // The result is packed as {borrow into top bit, borrow out, difference}.
  function automatic logic [DIGIT+1:0] sub_digit(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             c
  );
    logic [DIGIT-1:0] d;
    logic             cc;
    logic             cm;
    d  = '0;
    cc = c;
    cm = c;
    for (int i = 0; i < DIGIT; i++) begin
      cm   = cc;
      d[i] = x[i] ^ y[i] ^ cc;
      cc   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & cc);
    end
    return {cm, cc, d};
  endfunction

  // Next-state, digit datapath and completion logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    a_s     = a_r;
    b_s     = b_r;
    brw_s   = brw_r;
    res_s   = res_r;
    dif_s   = dif_r;
    bor_s   = bor_r;
    ovf_s   = ovf_r;
    done_s  = 1'b0;
    busy_s  = busy_r;
    idx_s   = int'(cnt_r) * DIGIT;
    step_s  = sub_digit(a_r[idx_s +: DIGIT], b_r[idx_s +: DIGIT], brw_r);
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = RUN;
          a_s     = bus.a;
          b_s     = bus.b;
          brw_s   = bus.bin;
          cnt_s   = '0;
          busy_s  = 1'b1;
        end else begin
          busy_s  = 1'b0;
        end
      end
      RUN: begin
        res_s[idx_s +: DIGIT] = step_s[DIGIT-1:0];
        brw_s = step_s[DIGIT];
        if (cnt_r == LAST) begin
          state_s = IDLE;
          cnt_s   = '0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          dif_s   = res_s;
          bor_s   = step_s[DIGIT];
          ovf_s   = step_s[DIGIT+1] ^ step_s[DIGIT];
        end else begin
          cnt_s   = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; rst aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      brw_r   <= 1'b0;
      res_r   <= '0;
      dif_r   <= '0;
      bor_r   <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      a_r     <= a_s;
      b_r     <= b_s;
      brw_r   <= brw_s;
      res_r   <= res_s;
      dif_r   <= dif_s;
      bor_r   <= bor_s;
      ovf_r   <= ovf_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.dif  = dif_r;
  assign bus.bor  = bor_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_seq_sub.sv
// Scoreboard bench for seq_sub: a DIGIT=4 instance under directed and random
// traffic, plus a DIGIT=16 instance for the single-cycle build.
module tb_seq_sub;
  localparam int W  = 16;
  localparam int N4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_sub_if #(.WIDTH(W)) sb ();
  seq_sub_if #(.WIDTH(W)) sw ();

  seq_sub #(.WIDTH(W), .DIGIT(4))  dut  (.clk(clk), .rst(rst), .bus(sb.slave));
  seq_sub #(.WIDTH(W), .DIGIT(16)) dutw (.clk(clk), .rst(rst), .bus(sw.slave));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    int          acc;
    int          dn;
  } op_t;

  op_t         q[$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  bit          rst_q  = 1'b0;
  logic [15:0] h_dif  = 16'h0000;
  logic        h_bor  = 1'b0;
  logic        h_ovf  = 1'b0;

  // Reference: plain integer arithmetic; returns {ovf, bor, dif}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic bin);
    int ua, ub, ubin, sd, sr;
    ua   = int'(a);
    ub   = int'(b);
    ubin = bin ? 1 : 0;
    sd   = ua - ub - ubin;
    sr   = int'($signed(a)) - int'($signed(b)) - ubin;
    return {(sr > 32767 || sr < -32768), (sd < 0), sd[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_q = rst;
  end

  // Monitor: expected busy/done/results derived from the scoreboard queue.
  always @(negedge clk) begin
    logic [17:0] r;
    logic        eb, ed;
    if (rst_q) begin
      q.delete();
      h_dif = 16'h0000;
      h_bor = 1'b0;
      h_ovf = 1'b0;
    end
    ed = (q.size() > 0) && (cyc == q[0].dn);
    eb = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].dn);
    chk("busy", sb.busy, eb);
    chk("done", sb.done, ed);
    if (ed) begin
      r     = model(q[0].a, q[0].b, q[0].bin);
      h_dif = r[15:0];
      h_bor = r[16];
      h_ovf = r[17];
    end
    chk("dif", sb.dif, h_dif);
    chk("bor", sb.bor, h_bor);
    chk("ovf", sb.ovf, h_ovf);
    if (q.size() > 0 && cyc >= q[0].dn) void'(q.pop_front());
  end

  // Called at posedge+2; drives one cycle of inputs and records accepted starts.
  task automatic drive_cycle(input logic s, input logic [15:0] a, input logic [15:0] b,
                             input logic bin);
    sb.start = s;
    sb.a     = a;
    sb.b     = b;
    sb.bin   = bin;
    if (s && !sb.busy && !rst)
      q.push_back('{a: a, b: b, bin: bin, acc: cyc + 1, dn: cyc + 1 + N4});
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    idle_cycle();
    while (sb.busy && n < 64) begin
      idle_cycle();
      n++;
    end
    if (sb.busy) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic expect_out(input string name, input logic [15:0] d, input logic bo,
                            input logic ov);
    chk({name, "_dif"}, sb.dif, d);
    chk({name, "_bor"}, sb.bor, bo);
    chk({name, "_ovf"}, sb.ovf, ov);
  endtask

  initial begin
    logic [17:0] r;
    logic [15:0] wa, wb;
    logic        wbin;
    rst      = 1'b1;
    sb.start = 1'b0; sb.a = 16'h0000; sb.b = 16'h0000; sb.bin = 1'b0;
    sw.start = 1'b0; sw.a = 16'h0000; sw.b = 16'h0000; sw.bin = 1'b0;
    @(posedge clk);
    #2;
    // Reset with start asserted and random operands.
    drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1);
    drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0);
    rst = 1'b0;
    expect_out("reset", 16'h0000, 1'b0, 1'b0);
    chk("reset_busy", sb.busy, 32'd0);
    idle_cycle();

    drive_cycle(1'b1, 16'h1234, 16'h0234, 1'b0);
    wait_idle();
    expect_out("basic", 16'h1000, 1'b0, 1'b0);
    idle_cycle(); idle_cycle();
    expect_out("basic_hold", 16'h1000, 1'b0, 1'b0);

    drive_cycle(1'b1, 16'h0000, 16'h0001, 1'b0);
    wait_idle();
    expect_out("ripple1", 16'hFFFF, 1'b1, 1'b0);
    drive_cycle(1'b1, 16'h0005, 16'h0005, 1'b1);
    wait_idle();
    expect_out("ripple2", 16'hFFFF, 1'b1, 1'b0);

    drive_cycle(1'b1, 16'h8000, 16'h0001, 1'b0);
    wait_idle();
    expect_out("ovf1", 16'h7FFF, 1'b0, 1'b1);
    drive_cycle(1'b1, 16'h7FFF, 16'hFFFF, 1'b0);
    wait_idle();
    expect_out("ovf2", 16'h8000, 1'b1, 1'b1);

    // Start while busy is ignored; start in the done cycle is accepted.
    drive_cycle(1'b1, 16'h0050, 16'h0020, 1'b0);
    idle_cycle();
    drive_cycle(1'b1, 16'hFFFF, 16'h0000, 1'b0);
    wait_idle();
    expect_out("ignore", 16'h0030, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h0010, 16'h0001, 1'b0);
    wait_idle();
    expect_out("b2b", 16'h000F, 1'b0, 1'b0);

    // Abort on the second RUN edge, then a fresh operation.
    drive_cycle(1'b1, 16'h4321, 16'h1111, 1'b0);
    idle_cycle();
    rst = 1'b1;
    idle_cycle();
    rst = 1'b0;
    expect_out("abort", 16'h0000, 1'b0, 1'b0);
    chk("abort_busy", sb.busy, 32'd0);
    for (int i = 0; i < 6; i++) idle_cycle();
    drive_cycle(1'b1, 16'h00A0, 16'h000B, 1'b1);
    wait_idle();
    expect_out("fresh", 16'h0094, 1'b0, 1'b0);

    for (int i = 0; i < 800; i++)
      drive_cycle(($urandom_range(0, 2) == 0), 16'($urandom), 16'($urandom), 1'($urandom));
    wait_idle();
    for (int i = 0; i < 3; i++) idle_cycle();
    chk("drain", q.size(), 32'd0);

    // Single-digit build: directed case first, then random operands.
    for (int i = 0; i < 20; i++) begin
      wa   = (i == 0) ? 16'h0003 : 16'($urandom);
      wb   = (i == 0) ? 16'h0005 : 16'($urandom);
      wbin = (i == 0) ? 1'b0 : 1'($urandom);
      chk("w_busy_idle", sw.busy, 32'd0);
      sw.start = 1'b1; sw.a = wa; sw.b = wb; sw.bin = wbin;
      @(posedge clk);
      #2;
      sw.start = 1'b0; sw.a = 16'($urandom); sw.b = 16'($urandom);
      chk("w_busy", sw.busy, 32'd1);
      chk("w_done_early", sw.done, 32'd0);
      @(posedge clk);
      #2;
      r = model(wa, wb, wbin);
      chk("w_done", sw.done, 32'd1);
      chk("w_dif", sw.dif, r[15:0]);
      chk("w_bor", sw.bor, r[16]);
      chk("w_ovf", sw.ovf, r[17]);
      if (i == 0) begin
        chk("w_fixed_dif", sw.dif, 32'h0000FFFE);
        chk("w_fixed_bor", sw.bor, 32'd1);
      end
      @(posedge clk);
      #2;
      chk("w_done_pulse", sw.done, 32'd0);
      chk("w_hold", sw.dif, r[15:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_sub.md
Name: seq_sub

Overview:
Parametrised multi-cycle subtractor. Computes a - b - bin over WIDTH-bit unsigned/two's-complement operands, DIGIT bits per clock, and ripples the borrow through a registered borrow flip-flop between digits. It is the area-lean, clocked successor to the team's single-bit full subtractor. It is used wherever a wide subtract is not timing-critical. A start/busy/done handshake frames each operation.

Parameters:
WIDTH, 16, operand and result width in bits (>= 2)
DIGIT, 4, bits processed per clock; WIDTH % DIGIT must be 0, otherwise elaboration error; DIGIT == WIDTH allowed

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only when busy=0
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  operation in progress
done  output  1  one-cycle pulse: results updated
dif  output  WIDTH  difference (a - b - bin) mod 2^WIDTH
bor  output  1  borrow-out: 1 iff a < b + bin (unsigned)
ovf  output  1  signed overflow: borrow into MSB XOR borrow out of MSB

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high. At an edge with rst=1, state goes to IDLE and busy=0, done=0, dif=0, bor=0, ovf=0. The operand and borrow registers are cleared. rst overrides start in the same cycle.
- Let N = WIDTH/DIGIT. The state machine has IDLE and RUN.
- IDLE, start=1 at edge E0:
  - capture a, b, bin; digit counter = 0; borrow FF = bin.
  - go to RUN; busy=1 from E0.
- RUN, edges E1..EN: at each edge, process digit k = counter (bits k*DIGIT+DIGIT-1 : k*DIGIT) using a DIGIT-bit ripple of full-subtractor cells:
  - d = x ^ y ^ c
  - c_next = (~x & y) | (~(x ^ y) & c)
  - the chain starts from the borrow FF.
  - the digit result is stored into the internal result register.
  - the borrow FF takes the chain's borrow-out.
  - the counter increments.
- At EN (last digit), in the same edge:
  - dif <= full result
  - bor <= final borrow
  - ovf <= (borrow into bit WIDTH-1) XOR (borrow out of bit WIDTH-1)
  - done <= 1, busy <= 0, go to IDLE.
- Latency is exactly N cycles from the accepting edge to done. With DIGIT == WIDTH, done follows 1 cycle after start.
- done is high for exactly one cycle. dif/bor/ovf hold their values until the next completion or reset. They do not change during RUN.
- start while busy=1 is ignored, with no queuing and no effect on the in-flight operands.
- Back-to-back: the done cycle is IDLE (busy=0), so start in that cycle is accepted. The next done follows N cycles later, giving a throughput of one result per N cycles.
- a/b/bin changing after acceptance has no effect.
- rst mid-RUN aborts the operation: no done pulse, outputs go to 0, and the next start behaves as from a fresh reset.
- Counter width is clog2(N), min 1. The counter never wraps mid-operation; it is cleared on accept.

Test Plan:
All cases use WIDTH=16, DIGIT=4 unless stated.
1. rst=1 for 2 cycles with start=1 and random a/b -> busy=0, done=0, dif=0x0000, bor=0, ovf=0. Start is ignored during reset.
2. start, a=0x1234, b=0x0234, bin=0 -> busy high exactly 4 cycles, done pulses 1 cycle at the 4th edge after accept. dif=0x1000, bor=0, ovf=0. Outputs hold afterwards.
3. Borrow ripple, in two runs:
   - a=0x0000, b=0x0001, bin=0 -> dif=0xFFFF, bor=1, ovf=0.
   - a=0x0005, b=0x0005, bin=1 -> dif=0xFFFF, bor=1, ovf=0.
4. Overflow, in two runs:
   - a=0x8000, b=0x0001, bin=0 -> dif=0x7FFF, bor=0, ovf=1.
   - a=0x7FFF, b=0xFFFF, bin=0 -> dif=0x8000, bor=1, ovf=1.
5. Handshake:
   - start again 2 cycles into a run with a=0xFFFF, b=0 -> ignored; first result is unchanged and only one done.
   - start in the done cycle with a=0x0010, b=0x0001 -> accepted; second done 4 cycles later, dif=0x000F.
6. Abort and degenerate width:
   - rst at the 2nd RUN edge -> next cycle busy=0, no done ever for that operation, outputs 0; a fresh start then completes correctly.
   - DIGIT=16 build, a=0x0003, b=0x0005 -> done 1 cycle after accept, dif=0xFFFE, bor=1, ovf=0.
